// File: rtl/chunked_serial_adder.sv
// Purpose: WIDTH-bit add/subtract computed CHUNK bits per clock through a registered carry.
// Latency: done pulses N = WIDTH/CHUNK cycles after the accept edge; one result per N+1 cycles back-to-back.
// Backpressure: ready is high only in IDLE/DONE; start is ignored while busy, and there is no output stall.
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Datapath for the current chunk.
    logic [31:0]      base;
    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic [CHUNK:0]   ch_sum;
    logic             msb_cin;
    logic [WIDTH-1:0] work_ins;
    logic             last;
    logic             accept;

    // Chunk adder: one CHUNK+1 bit add of the selected operand slices plus the running carry.
    always_comb begin
        base     = 32'(idx_q) * 32'(CHUNK);
        a_ch     = a_q[base +: CHUNK];
        b_ch     = b_q[base +: CHUNK];
        ch_sum   = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
        // The carry into any bit position is a ^ b ^ sum at that position, which
        // recovers the carry into the MSB for every CHUNK, including CHUNK=1.
        msb_cin  = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ ch_sum[CHUNK-1];
        work_ins = work_q;
        work_ins[base +: CHUNK] = ch_sum[CHUNK-1:0];
        last     = (idx_q == IW'(N - 1));
        accept   = start && (state_q != S_RUN);
    end

    // Next-state, operand latching and result publication.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    // Subtraction is A + ~B + 1, so the operand is inverted once here.
                    a_d     = A;
                    b_d     = sub ? ~B : B;
                    carry_d = sub ? 1'b1 : Cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                work_d  = work_ins;
                carry_d = ch_sum[CHUNK];
                if (last) begin
                    // Publish on the final edge so sum never shows a partial result.
                    sum_d   = work_ins;
                    cout_d  = ch_sum[CHUNK];
                    ovf_d   = msb_cin ^ ch_sum[CHUNK];
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous reset that aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready = (state_q != S_RUN);
    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed bench driving three adders (CHUNK=4, 1, 16; WIDTH=16) from shared inputs.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected values are hand-computed constants.
module tb_chunked_serial_adder;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic        Cin;
    logic [15:0] A;
    logic [15:0] B;

    logic [2:0]  rdy;
    logic [2:0]  bsy;
    logic [2:0]  dn;
    logic [2:0]  co;
    logic [2:0]  ov;
    logic [15:0] sm [3];

    int checks = 0;
    int errors = 0;

    // Expected latency (N) of each instance: CHUNK=4, CHUNK=1, CHUNK=16.
    int nn [3] = '{4, 16, 1};

    chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B), .Cin(Cin),
        .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .sum(sm[0]), .cout(co[0]), .ovf(ov[0])
    );

    chunked_serial_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B), .Cin(Cin),
        .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .sum(sm[1]), .cout(co[1]), .ovf(ov[1])
    );

    chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B), .Cin(Cin),
        .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .sum(sm[2]), .cout(co[2]), .ovf(ov[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reset asserted between edges must take effect without waiting for a clock.
    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sm[k] !== 16'h0000 || co[k] !== 1'b0 || ov[k] !== 1'b0 ||
                dn[k] !== 1'b0 || bsy[k] !== 1'b0 || rdy[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset dut%0d: got sum=%h cout=%b ovf=%b done=%b busy=%b ready=%b required 0000 0 0 0 0 1",
                         k, sm[k], co[k], ov[k], dn[k], bsy[k], rdy[k]);
            end
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One operation on all three instances: latency, result, single-cycle done, input latching.
    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic s, input logic [15:0] es,
                          input logic ec, input logic eo);
        bit seen [3];
        int lat  [3];
        for (int k = 0; k < 3; k++) begin
            seen[k] = 1'b0;
            lat[k]  = 0;
        end
        @(negedge clk);
        A = a; B = b; Cin = ci; sub = s; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                // Scramble inputs: operands are already latched.
                start = 1'b0; A = ~a; B = ~b; Cin = ~ci; sub = ~s;
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (bsy[k] !== 1'b1) begin
                        errors++;
                        $display("FAIL %s busy dut%0d: got %b required 1", name, k, bsy[k]);
                    end
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (seen[k] && c == lat[k] + 2) begin
                    checks++;
                    if (dn[k] !== 1'b0) begin
                        errors++;
                        $display("FAIL %s done_pulse dut%0d: got done=%b one cycle later required 0", name, k, dn[k]);
                    end
                end
                if (dn[k] === 1'b1 && !seen[k]) begin
                    seen[k] = 1'b1;
                    lat[k]  = c - 1;
                    checks++;
                    if (lat[k] != nn[k]) begin
                        errors++;
                        $display("FAIL %s latency dut%0d: got %0d required %0d", name, k, lat[k], nn[k]);
                    end
                    checks++;
                    if (sm[k] !== es) begin
                        errors++;
                        $display("FAIL %s sum dut%0d: got %h required %h", name, k, sm[k], es);
                    end
                    checks++;
                    if (co[k] !== ec) begin
                        errors++;
                        $display("FAIL %s cout dut%0d: got %b required %b", name, k, co[k], ec);
                    end
                    checks++;
                    if (ov[k] !== eo) begin
                        errors++;
                        $display("FAIL %s ovf dut%0d: got %b required %b", name, k, ov[k], eo);
                    end
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (!seen[k]) begin
                checks++;
                errors++;
                $display("FAIL %s timeout dut%0d: got no done required done after %0d cycles", name, k, nn[k]);
            end
        end
        A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
    endtask

    task automatic test_add();
        run_op("add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("add_cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    endtask

    task automatic test_carry_chain();
        run_op("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    endtask

    task automatic test_overflow_sub();
        run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    endtask

    // start held through RUN, then a second op accepted in the DONE cycle (CHUNK=4 instance).
    task automatic test_back_to_back();
        int  first  = 0;
        int  second = 0;
        bit  stable = 1'b1;
        @(negedge clk);
        A = 16'h1111; B = 16'h2222; Cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) begin
                A = 16'hAAAA; B = 16'h5555;
            end
            if (first != 0 && c == first + 1) start = 1'b0;
            if (dn[0] === 1'b1) begin
                if (first == 0) begin
                    first = c;
                    checks++;
                    if (sm[0] !== 16'h3333 || co[0] !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b first_result: got %h/%b required 3333/0", sm[0], co[0]);
                    end
                    A = 16'h0F0F; B = 16'h0101;
                end else if (second == 0) begin
                    second = c;
                    checks++;
                    if (sm[0] !== 16'h1010) begin
                        errors++;
                        $display("FAIL b2b second_result: got %h required 1010", sm[0]);
                    end
                end
            end else if (first != 0 && second == 0) begin
                if (sm[0] !== 16'h3333) stable = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (first != 5) begin
            errors++;
            $display("FAIL b2b first_latency: got %0d required 5", first - 1);
        end
        checks++;
        if (second - first != 5) begin
            errors++;
            $display("FAIL b2b spacing: got %0d required 5", second - first);
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL b2b sum_stable: got change between done pulses required hold 3333");
        end
        repeat (40) @(negedge clk);
        A = '0; B = '0;
    endtask

    // Reset two RUN cycles into an operation: immediate zero outputs, no done, then normal service.
    task automatic test_reset_mid_run();
        int dcount = 0;
        @(negedge clk);
        A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sm[k] !== 16'h0000 || co[k] !== 1'b0 || ov[k] !== 1'b0 ||
                dn[k] !== 1'b0 || bsy[k] !== 1'b0 || rdy[k] !== 1'b1) begin
                errors++;
                $display("FAIL midrun_reset dut%0d: got sum=%h cout=%b ovf=%b done=%b busy=%b ready=%b required 0000 0 0 0 0 1",
                         k, sm[k], co[k], ov[k], dn[k], bsy[k], rdy[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (dn !== 3'b000) dcount++;
        end
        checks++;
        if (dcount != 0) begin
            errors++;
            $display("FAIL midrun_no_done: got %0d done cycles required 0", dcount);
        end
        run_op("after_reset", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; sub = 1'b0; Cin = 1'b0; A = '0; B = '0;
        test_reset();
        test_add();
        test_carry_chain();
        test_overflow_sub();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
